// File: rtl/alu_ctrl.sv
// alu_ctrl: command sequencer driving an external combinational ALU, with an 8 x 64-bit register file.
// Optional carry chain (carry_flag / alu_carry) is built when ALU_CTRL_CARRY_EN is defined.
//
// state   | meaning
// S_IDLE  | ready for a command; LOAD and reserved opcodes go straight to S_WRITE
// S_READ  | drive ALU operands from the register file
// S_EXEC  | capture the ALU result
// S_WRITE | write back, update flags, pulse done (and err for reserved opcodes)
module alu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [4:0]  cmd_op_i,
  input  logic [2:0]  cmd_rd_i,
  input  logic [2:0]  cmd_ra_i,
  input  logic [2:0]  cmd_rb_i,
  input  logic [63:0] cmd_imm_i,
  output logic [63:0] alu_a_o,
  output logic [63:0] alu_b_o,
  output logic [4:0]  alu_fsec_o,
  output logic        alu_carry_o,
  input  logic [63:0] alu_fout_i,
  output logic        done_o,
  output logic        err_o,
  output logic        zero_flag_o,
  output logic        carry_flag_o,
  input  logic [2:0]  dbg_addr_i,
  output logic [63:0] dbg_data_o
);

  localparam logic [4:0] OP_ALU_MAX = 5'b01110;
  localparam logic [4:0] OP_LOAD    = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  ra_q, ra_d;
  logic [2:0]  rb_q, rb_d;
  logic [63:0] imm_q, imm_d;
  logic [63:0] result_q, result_d;
  logic [63:0] alu_a_q, alu_a_d;
  logic [63:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_fsec_q, alu_fsec_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        zero_q, zero_d;
  logic [63:0] rf_q [8];
  logic        wr_en;
  logic [63:0] wr_data;

  function automatic logic is_alu_op(input logic [4:0] op);
    return op <= OP_ALU_MAX;
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    imm_d      = imm_q;
    result_d   = result_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_fsec_d = alu_fsec_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = result_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          rd_d    = cmd_rd_i;
          ra_d    = cmd_ra_i;
          rb_d    = cmd_rb_i;
          imm_d   = cmd_imm_i;
          state_d = is_alu_op(cmd_op_i) ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        alu_a_d    = rf_q[ra_q];
        alu_b_d    = rf_q[rb_q];
        alu_fsec_d = op_q;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_fout_i;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (is_alu_op(op_q)) begin
          wr_en   = 1'b1;
          wr_data = result_q;
        end else if (op_q == OP_LOAD) begin
          wr_en   = 1'b1;
          wr_data = imm_q;
        end else begin
          err_d = 1'b1;
        end
        if (wr_en) zero_d = (wr_data == 64'd0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      imm_q      <= '0;
      result_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fsec_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      zero_q     <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      imm_q      <= imm_d;
      result_q   <= result_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fsec_q <= alu_fsec_d;
      done_q     <= done_d;
      err_q      <= err_d;
      zero_q     <= zero_d;
      if (wr_en) rf_q[rd_q] <= wr_data;
    end
  end

`ifdef ALU_CTRL_CARRY_EN
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_ADC = 5'b00011;
  localparam logic [4:0] OP_INC = 5'b00100;

  logic        carry_flag_q, carry_flag_d;
  logic        alu_carry_q, alu_carry_d;
  logic [64:0] sum65;

  // The carry is recomputed from the held operands rather than taken from the ALU.
  always_comb begin
    carry_flag_d = carry_flag_q;
    alu_carry_d  = alu_carry_q;
    case (op_q)
      OP_ADC:  sum65 = {1'b0, alu_a_q} + {1'b0, alu_b_q} + {64'd0, alu_carry_q};
      OP_INC:  sum65 = {1'b0, alu_a_q} + 65'd1;
      default: sum65 = {1'b0, alu_a_q} + {1'b0, alu_b_q};
    endcase
    if (state_q == S_READ) alu_carry_d = carry_flag_q;
    if (state_q == S_WRITE && (op_q == OP_ADD || op_q == OP_ADC || op_q == OP_INC))
      carry_flag_d = sum65[64];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag_q <= 1'b0;
      alu_carry_q  <= 1'b0;
    end else begin
      carry_flag_q <= carry_flag_d;
      alu_carry_q  <= alu_carry_d;
    end
  end

  assign carry_flag_o = carry_flag_q;
  assign alu_carry_o  = alu_carry_q;
`else
  assign carry_flag_o = 1'b0;
  assign alu_carry_o  = 1'b0;
`endif

  assign cmd_ready_o = (state_q == S_IDLE);
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_fsec_o  = alu_fsec_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign zero_flag_o = zero_q;
  assign dbg_data_o  = rf_q[dbg_addr_i];

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows: clk  in  1  rising-edge clock.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 cmd_valid  in  1  command present.
REQ-004 cmd_ready  out  1  block can accept a command.
REQ-005 cmd_op  in  5  ALU opcode 00000-01110, 10000 = LOAD, other values reserved.
REQ-006 cmd_rd, cmd_ra, cmd_rb  in  3 each  destination, operand-A and operand-B register indices.
REQ-007 cmd_imm  in  64  immediate, used only by LOAD.
REQ-008 alu_a, alu_b  out  64 each  ALU operand drive.
REQ-009 alu_fsec  out  5  ALU opcode drive.
REQ-010 alu_carry  out  1  ALU carry-in drive.
REQ-011 alu_fout  in  64  ALU result (combinational, same cycle).
REQ-012 done  out  1  one-cycle pulse when a command retires.
REQ-013 err  out  1  one-cycle pulse, coincident with done, for a reserved opcode.
REQ-014 zero_flag, carry_flag  out  1 each  status flags.
REQ-015 dbg_addr  in  3; dbg_data  out  64  combinational register-file read port.

Function
REQ-016 The block SHALL contain 8 x 64-bit registers and a 4-state FSM: IDLE, READ, EXEC, WRITE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on cmd_valid && cmd_ready, latching op, rd, ra, rb and imm.
REQ-018 For an ALU opcode accepted at edge T: READ registers alu_a=rf[ra], alu_b=rf[rb] and alu_fsec=op; EXEC captures alu_fout; WRITE writes rf[rd]; done is high in the cycle after edge T+3.
REQ-019 For LOAD, IDLE SHALL go to WRITE directly and write cmd_imm to rf[rd], with done at T+1 (2 cycles total).
REQ-020 A reserved opcode SHALL go IDLE->WRITE with no register write and no flag update, and SHALL pulse done and err.
REQ-021 alu_a, alu_b, alu_fsec and alu_carry SHALL hold their values from READ until the next READ.
REQ-022 Operands SHALL be read in READ; ra or rb equal to rd SHALL use the pre-write value.
REQ-023 zero_flag SHALL update in WRITE to (written value == 0) for every ALU op and for LOAD.
REQ-024 dbg_data SHALL equal rf[dbg_addr]; a read in the same cycle as a write to that address SHALL return the old value.
REQ-025 cmd_valid in a non-IDLE state SHALL be ignored; no command SHALL be lost or queued.
REQ-026 Arithmetic SHALL be modulo 2^64; the block SHALL NOT check or modify alu_fout.

Reset
REQ-027 When rst_n is low, all registers, alu_a, alu_b, alu_fsec, alu_carry, zero_flag and carry_flag SHALL be 0, the FSM SHALL be IDLE, and done and err SHALL be 0.
REQ-028 If reset is asserted mid-command, the command SHALL be discarded with no write-back and no done; cmd_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-029 With ALU_CTRL_CARRY_EN defined, carry_flag SHALL update in WRITE to bit 64 of the 65-bit sum for ops 00010 (A+B), 00011 (A+B+carry_flag) and 00100 (A+1), and SHALL hold otherwise.
REQ-030 With ALU_CTRL_CARRY_EN defined, alu_carry SHALL equal carry_flag as sampled at READ.
REQ-031 Without ALU_CTRL_CARRY_EN, carry_flag and alu_carry SHALL be constant 0, and op 00011 SHALL behave as A+B.

Verification
REQ-032 LOAD r1=5 (cmd_op=10000, cmd_imm=5); then LOAD r2=3 -> done 1 cycle after each accept; dbg_addr=1 reads 5; zero_flag=0.
REQ-033 op 00110, rd=3, ra=1, rb=2 -> alu_fsec=00110 and alu_a=5, alu_b=3 after READ; done at T+3; rf[3]=2.
REQ-034 LOAD r1=all ones; op 00100, rd=4, ra=1 -> rf[4]=0, zero_flag=1, and carry_flag=1 (with _EN) or 0 (without).
REQ-035 Hold cmd_valid high for 10 cycles with op 01001 -> exactly 3 commands accepted (cycles 0, 4, 8); cmd_ready low in READ, EXEC and WRITE.
REQ-036 op 10101 -> done=1 and err=1 for one cycle; no register or flag changes.
REQ-037 Assert rst_n low in EXEC of op 01000 to r1 holding 7 -> r1=0 (reset), no done; the next LOAD is accepted normally.
